// File: rtl/apb_uart_pkg.sv
// ---------------------------------------------------------------------------
// apb_uart_pkg
// Definitions shared by the UART TX and RX controllers:
//   tx_state_e       - transmit sequencer states
//   DB5..DB8         - line-control data-bits codes (5..8 data bits)
//   OVERSAMPLE_DFLT  - default number of oversample ticks per bit
//   parity_calc()    - parity bit for a 5..8-bit character
// ---------------------------------------------------------------------------
package apb_uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

   localparam logic [1:0] DB5 = 2'b00;
   localparam logic [1:0] DB6 = 2'b01;
   localparam logic [1:0] DB7 = 2'b10;
   localparam logic [1:0] DB8 = 2'b11;

   localparam int OVERSAMPLE_DFLT = 16;

   // Parity over the low (5 + nbits_code) bits of data. Even parity makes the
   // total count of ones (data + parity) even; odd parity inverts that.
   // Stick parity ignores the data and sends the inverse of the even flag.
   function automatic logic parity_calc(input logic [7:0] data,
                                        input logic [1:0] nbits_code,
                                        input logic       even,
                                        input logic       stick);
      logic p;
      p = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i < (5 + int'(nbits_code))) begin
            p = p ^ data[i];
         end else begin
            p = p;
         end
      end
      if (stick) begin
         return ~even;
      end else begin
         return even ? p : ~p;
      end
   endfunction

endpackage

// File: rtl/apb_uart_bit_timer.sv
// ---------------------------------------------------------------------------
// apb_uart_bit_timer
// Counts oversample strobes and flags the last strobe of each bit period.
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   en_i          - counter runs while high; held at zero while low
//   tick_i        - single-cycle oversample strobe
//   bit_end_o     - high on the tick_i that completes a bit period
// ---------------------------------------------------------------------------
module apb_uart_bit_timer #(
   parameter int OVERSAMPLE = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en_i,
   input  logic tick_i,
   output logic bit_end_o
);

   localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(OVERSAMPLE - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign bit_end_o = en_i & tick_i & (cnt_q == LAST_CNT);

   // Next tick count: clear when disabled, wrap at end of bit, hold without tick.
   always_comb begin
      cnt_d = cnt_q;
      if (!en_i) begin
         cnt_d = '0;
      end else if (tick_i) begin
         cnt_d = bit_end_o ? '0 : (cnt_q + CW'(1));
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Tick counter register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/apb_uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// apb_uart_tx_ctrl
// UART transmit sequencer: pops bytes from the TX FIFO and serialises each one
// as start bit, 5..8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Ports:
//   clk, reset_n      - clock, asynchronous active-low reset
//   tick_i            - oversample strobe from the baud generator
//   tx_en_i           - allows a new frame to start
//   data_bits_i       - data-bits code (00=5 .. 11=8)
//   stop_bits_i       - 0: one stop bit, 1: two stop bits
//   parity_en_i       - parity bit present
//   parity_even_i     - 1: even parity, 0: odd parity
//   parity_stick_i    - parity bit forced to ~parity_even_i
//   break_i           - force the line low
//   fifo_valid_i      - TX FIFO not empty
//   fifo_data_i       - TX FIFO head word
//   fifo_ready_o      - pop strobe to the TX FIFO (combinational)
//   tx_o              - serial line, idle high (registered)
//   busy_o            - frame in progress
//   frame_done_o      - pulse on the final tick of the last stop bit
// ---------------------------------------------------------------------------
module apb_uart_tx_ctrl
   import apb_uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int OVERSAMPLE = OVERSAMPLE_DFLT
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  tick_i,
   input  logic                  tx_en_i,
   input  logic [1:0]            data_bits_i,
   input  logic                  stop_bits_i,
   input  logic                  parity_en_i,
   input  logic                  parity_even_i,
   input  logic                  parity_stick_i,
   input  logic                  break_i,
   input  logic                  fifo_valid_i,
   input  logic [DATA_WIDTH-1:0] fifo_data_i,
   output logic                  fifo_ready_o,
   output logic                  tx_o,
   output logic                  busy_o,
   output logic                  frame_done_o
);

   tx_state_e  state_q, state_d;
   logic [7:0] shift_q, shift_d;
   logic [1:0] db_q, db_d;
   logic       stop2_q, stop2_d;
   logic       par_en_q, par_en_d;
   logic       par_q, par_d;
   logic [2:0] idx_q, idx_d;
   logic       tx_q, tx_d;

   logic       bit_end_s;
   logic       can_pop_s;
   logic       pop_s;
   logic       done_s;
   logic       line_s;
   logic [2:0] last_idx_s;

   // The counter only runs inside a frame, so every frame starts on a fresh bit.
   apb_uart_bit_timer #(
      .OVERSAMPLE (OVERSAMPLE)
   ) u_bit_timer (
      .clk       (clk),
      .reset_n   (reset_n),
      .en_i      (state_q != IDLE),
      .tick_i    (tick_i),
      .bit_end_o (bit_end_s)
   );

   assign can_pop_s = fifo_valid_i & tx_en_i;

   // Sequencer next state, pop/done strobes, frame latching and next line bit.
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      db_d     = db_q;
      stop2_d  = stop2_q;
      par_en_d = par_en_q;
      par_d    = par_q;
      idx_d    = idx_q;
      pop_s    = 1'b0;
      done_s   = 1'b0;
      line_s   = 1'b1;

      case (db_q)
         DB5:     last_idx_s = 3'd4;
         DB6:     last_idx_s = 3'd5;
         DB7:     last_idx_s = 3'd6;
         DB8:     last_idx_s = 3'd7;
         default: last_idx_s = 3'd7;
      endcase

      case (state_q)
         IDLE: begin
            if (can_pop_s) begin
               pop_s   = 1'b1;
               state_d = START;
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            if (bit_end_s) begin
               state_d = DATA;
               idx_d   = 3'd0;
            end else begin
               state_d = START;
            end
         end
         DATA: begin
            if (bit_end_s) begin
               shift_d = {1'b0, shift_q[7:1]};
               if (idx_q == last_idx_s) begin
                  idx_d   = 3'd0;
                  state_d = par_en_q ? PARITY : STOP;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               state_d = DATA;
            end
         end
         PARITY: begin
            if (bit_end_s) begin
               state_d = STOP;
               idx_d   = 3'd0;
            end else begin
               state_d = PARITY;
            end
         end
         STOP: begin
            if (bit_end_s) begin
               // idx_q counts stop bits already sent when two are configured
               if (stop2_q && (idx_q == 3'd0)) begin
                  idx_d = 3'd1;
               end else begin
                  done_s = 1'b1;
                  idx_d  = 3'd0;
                  if (can_pop_s) begin
                     pop_s   = 1'b1;
                     state_d = START;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end else begin
               state_d = STOP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Frame word and configuration are captured together with the pop.
      if (pop_s) begin
         shift_d  = fifo_data_i[7:0];
         db_d     = data_bits_i;
         stop2_d  = stop_bits_i;
         par_en_d = parity_en_i;
         par_d    = parity_calc(fifo_data_i[7:0], data_bits_i,
                                parity_even_i, parity_stick_i);
      end else begin
         db_d     = db_q;
         stop2_d  = stop2_q;
         par_en_d = par_en_q;
         par_d    = par_q;
      end

      // Line value follows the next state so tx_o changes with the state.
      case (state_d)
         IDLE:    line_s = 1'b1;
         START:   line_s = 1'b0;
         DATA:    line_s = shift_d[0];
         PARITY:  line_s = par_d;
         STOP:    line_s = 1'b1;
         default: line_s = 1'b1;
      endcase

      tx_d = break_i ? 1'b0 : line_s;
   end

   // Sequencer and line registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         shift_q  <= 8'h00;
         db_q     <= 2'b00;
         stop2_q  <= 1'b0;
         par_en_q <= 1'b0;
         par_q    <= 1'b0;
         idx_q    <= 3'd0;
         tx_q     <= 1'b1;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         db_q     <= db_d;
         stop2_q  <= stop2_d;
         par_en_q <= par_en_d;
         par_q    <= par_d;
         idx_q    <= idx_d;
         tx_q     <= tx_d;
      end
   end

   assign fifo_ready_o = pop_s;
   assign frame_done_o = done_s;
   assign busy_o       = (state_q != IDLE);
   assign tx_o         = tx_q;

endmodule
